// File: rtl/rv_pkg.sv
// Shared RV32I core constants and the fetch-stage state encoding.
package rv_pkg;
  localparam int XLEN = 32;
  localparam int ILEN = 32;

  // RUN: fetching; DRAIN: discarding stale responses; FAULT: parked on a misaligned target
  typedef enum logic [1:0] {RUN, DRAIN, FAULT} state_e;
endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count and synchronous flush.
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         push,
  input  logic [WIDTH-1:0]             wdata,
  input  logic                         pop,
  output logic [WIDTH-1:0]             rdata,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         empty,
  output logic                         full
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Storage, pointers and count; flush drops everything and wins over push/pop
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/if_stage.sv
// RV32I instruction-fetch stage: issues in-order word fetches from pc_current,
// pairs each returned word with its PC and hands the pair to decode.
// Optional IF_MISALIGN_TRAP_EN: misaligned redirect targets park the stage in
// FAULT and expose fetch_fault/fault_pc; otherwise the low PC bits are masked.
module if_stage import rv_pkg::*; #(
  parameter int XLEN  = rv_pkg::XLEN,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc_current,
  output logic [XLEN-1:0] pc_next,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [ILEN-1:0] imem_resp_data,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [ILEN-1:0] if_instr,
  output logic [XLEN-1:0] if_pc
`ifdef IF_MISALIGN_TRAP_EN
  ,
  output logic            fetch_fault,
  output logic [XLEN-1:0] fault_pc
`endif
);
  localparam int CW = $clog2(DEPTH + 1);

  state_e                 state;
  logic [CW-1:0]          inflight, out_count, inflight_after;
  logic [CW:0]            occupancy;
  logic                   accept, out_push, out_pop;
  logic                   out_empty, out_full, pend_empty, pend_full;
  logic [XLEN-1:0]        pend_head;
  logic [XLEN+ILEN-1:0]   out_head;
`ifdef IF_MISALIGN_TRAP_EN
  logic                   fault_pend;
  logic                   misalign;
  assign misalign = |redirect_pc[1:0];
`endif

  // Capacity uses registered counts only, so every issued fetch is guaranteed a buffer slot
  assign occupancy      = {1'b0, inflight} + {1'b0, out_count};
  assign imem_req_valid = rst && (state == RUN) && (occupancy < (CW+1)'(DEPTH)) && !redirect_valid;
  assign imem_req_addr  = {pc_current[XLEN-1:2], 2'b00};
  assign accept         = imem_req_valid && imem_req_ready;
  assign pc_next        = redirect_valid ? redirect_pc :
                          accept         ? pc_current + XLEN'(4) : pc_current;
  // No request is accepted while redirecting or draining, so only the response matters here
  assign inflight_after = inflight - CW'(imem_resp_valid);

  assign out_push = imem_resp_valid && (state == RUN);
  assign if_valid = !out_empty;
  assign out_pop  = if_valid && if_ready;
  assign if_instr = if_valid ? out_head[ILEN-1:0] : '0;
  assign if_pc    = if_valid ? out_head[XLEN+ILEN-1:ILEN] : '0;

  sync_fifo #(.WIDTH(XLEN), .DEPTH(DEPTH)) u_pend_pc (
    .clk(clk), .rst(rst), .flush(1'b0),
    .push(accept), .wdata(pc_current),
    .pop(imem_resp_valid), .rdata(pend_head),
    .count(inflight), .empty(pend_empty), .full(pend_full)
  );

  sync_fifo #(.WIDTH(XLEN + ILEN), .DEPTH(DEPTH)) u_out_buf (
    .clk(clk), .rst(rst), .flush(redirect_valid),
    .push(out_push), .wdata({pend_head, imem_resp_data}),
    .pop(out_pop), .rdata(out_head),
    .count(out_count), .empty(out_empty), .full(out_full)
  );

  // Redirect/drain control: stale responses are discarded until the in-flight count hits zero
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= RUN;
`ifdef IF_MISALIGN_TRAP_EN
      fault_pend  <= 1'b0;
      fetch_fault <= 1'b0;
      fault_pc    <= '0;
`endif
    end else if (redirect_valid) begin
`ifdef IF_MISALIGN_TRAP_EN
      fault_pend  <= misalign;
      if (misalign) fault_pc <= redirect_pc;
      fetch_fault <= misalign && (inflight_after == '0);
      if (inflight_after != '0) state <= DRAIN;
      else                      state <= misalign ? FAULT : RUN;
`else
      state <= (inflight_after != '0) ? DRAIN : RUN;
`endif
    end else if (state == DRAIN && inflight_after == '0) begin
`ifdef IF_MISALIGN_TRAP_EN
      state       <= fault_pend ? FAULT : RUN;
      fetch_fault <= fault_pend;
`else
      state <= RUN;
`endif
    end
  end

  a_resp_has_pending: assert property (@(posedge clk) disable iff (!rst) imem_resp_valid |-> !pend_empty);
  a_no_accept_full:   assert property (@(posedge clk) disable iff (!rst) accept |-> !pend_full);
  a_no_push_full:     assert property (@(posedge clk) disable iff (!rst) out_push |-> !out_full);
endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: a PC register and in-order memory model drive the
// DUT; each accepted fetch pushes its expected {pc, instr} to a scoreboard queue
// that is popped and compared on every decode handshake.
module tb_if_stage;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_current, pc_next, redirect_pc, imem_req_addr, imem_resp_data, if_instr, if_pc;
  logic        redirect_valid, imem_req_valid, imem_req_ready, imem_resp_valid, if_valid, if_ready;
`ifdef IF_MISALIGN_TRAP_EN
  logic        fetch_fault;
  logic [31:0] fault_pc;
`endif

  typedef struct packed {logic [31:0] pc; logic [31:0] instr;} exp_t;
  exp_t        exp_q[$];
  logic [31:0] mq[$];
  int          mt[$];
  int          n_cmp = 0, n_bad = 0, cyc = 0, lat = 1, acc_cnt = 0, delivered = 0, d0;
  logic        watch = 1'b0, wrap_seen = 1'b0;
  logic [31:0] watch_pc;

  always #5 clk = ~clk;

  if_stage #(.XLEN(32), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .pc_current(pc_current), .pc_next(pc_next),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc)
`ifdef IF_MISALIGN_TRAP_EN
    , .fetch_fault(fetch_fault), .fault_pc(fault_pc)
`endif
  );

  task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: sample/check at negedge, then advance the PC register and memory after posedge
  task automatic step();
    logic        acc;
    logic [31:0] ex, nxt;
    exp_t        e;
    @(negedge clk);
    acc = imem_req_valid && imem_req_ready;
    if (acc) acc_cnt++;
    ex = redirect_valid ? redirect_pc : (acc ? pc_current + 32'd4 : pc_current);
    chk(pc_next, ex, "pc_next");
    if (redirect_valid) chk({31'b0, imem_req_valid}, 32'd0, "req_in_redirect");
    if (acc) begin
      chk(imem_req_addr, {pc_current[31:2], 2'b00}, "req_addr");
      if (pc_current == 32'hFFFF_FFFC) begin
        chk(pc_next, 32'd0, "pc_wrap");
        wrap_seen = 1'b1;
      end
      mq.push_back({pc_current[31:2], 2'b00});
      mt.push_back(cyc + lat);
      exp_q.push_back({pc_current, ~{pc_current[31:2], 2'b00}});
    end
    if (if_valid && if_ready) begin
      delivered++;
      if (exp_q.size() == 0) chk({31'b0, if_valid}, 32'd0, "unexpected_instr");
      else begin
        e = exp_q.pop_front();
        chk(if_pc, e.pc, "if_pc");
        chk(if_instr, e.instr, "if_instr");
        if (watch) begin
          chk(if_pc, watch_pc, "first_after_redirect");
          watch = 1'b0;
        end
      end
    end
    if (redirect_valid) exp_q.delete();
    nxt = pc_next;
    @(posedge clk);
    #1;
    cyc++;
    pc_current = nxt;
    if (mq.size() > 0 && mt[0] <= cyc) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = ~mq.pop_front();
      void'(mt.pop_front());
    end else begin
      imem_resp_valid = 1'b0;
    end
  endtask

  task automatic redirect(input logic [31:0] tgt);
    redirect_valid = 1'b1;
    redirect_pc    = tgt;
    step();
    redirect_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b0; pc_current = '0; redirect_valid = 1'b0; redirect_pc = '0;
    imem_req_ready = 1'b1; imem_resp_valid = 1'b0; imem_resp_data = '0; if_ready = 1'b0;

    // Reset state
    @(negedge clk);
    chk({31'b0, imem_req_valid}, 32'd0, "rst_req_valid");
    chk({31'b0, if_valid}, 32'd0, "rst_if_valid");
    chk(if_instr, 32'd0, "rst_if_instr");
    chk(if_pc, 32'd0, "rst_if_pc");
`ifdef IF_MISALIGN_TRAP_EN
    chk({31'b0, fetch_fault}, 32'd0, "rst_fetch_fault");
    chk(fault_pc, 32'd0, "rst_fault_pc");
`endif
    @(posedge clk);
    #1 rst = 1'b1;

    // Decode stalled from the start: exactly DEPTH fetches, then PC holds
    acc_cnt = 0;
    repeat (8) step();
    chk(acc_cnt, DEPTH, "stall_fetch_count");
    chk(32'(exp_q.size()), DEPTH, "stall_buffered");
    chk({31'b0, imem_req_valid}, 32'd0, "stall_req_valid");
    chk(pc_current, 32'h10, "stall_pc_hold");
    chk({31'b0, if_valid}, 32'd1, "stall_if_valid");

    // Resume: one instruction per cycle once the pipe refills
    if_ready = 1'b1;
    repeat (3) step();
    d0 = delivered;
    repeat (8) step();
    chk(delivered - d0, 8, "stream_throughput");

    // Memory ready toggling: pc_next only advances on accepted cycles
    repeat (8) begin
      imem_req_ready = ~imem_req_ready;
      step();
    end
    imem_req_ready = 1'b1;

    // Redirect with two or more fetches in flight: drain, then restart at 0x100
    lat = 3;
    for (int i = 0; i < 20 && (mq.size() + int'(imem_resp_valid)) < 2; i++) step();
    chk({31'b0, (mq.size() + int'(imem_resp_valid)) >= 2}, 32'd1, "two_in_flight");
    redirect(32'h100);
    chk({31'b0, if_valid}, 32'd0, "flush_if_valid");
    for (int i = 0; i < 20 && (mq.size() > 0 || imem_resp_valid); i++) begin
      chk({31'b0, if_valid}, 32'd0, "drain_if_valid");
      chk({31'b0, imem_req_valid}, 32'd0, "drain_req_valid");
      step();
    end
    watch = 1'b1; watch_pc = 32'h100;
    lat = 1;
    repeat (8) step();
    chk({31'b0, watch}, 32'd0, "delivered_after_drain");

    // Redirect coinciding with a response and a decode pop
    for (int i = 0; i < 20 && !(imem_resp_valid && if_valid); i++) step();
    chk({31'b0, imem_resp_valid && if_valid}, 32'd1, "coincide_setup");
    redirect(32'h200);
    chk({31'b0, if_valid}, 32'd0, "coincide_flush");
    watch = 1'b1; watch_pc = 32'h200;
    repeat (8) step();
    chk({31'b0, watch}, 32'd0, "delivered_after_coincide");

    // PC wraps past the top of the address space
    redirect(32'hFFFF_FFFC);
    for (int i = 0; i < 10 && !wrap_seen; i++) step();
    chk({31'b0, wrap_seen}, 32'd1, "wrap_reached");
    repeat (4) step();

    // Misaligned redirect target
    redirect(32'h102);
`ifdef IF_MISALIGN_TRAP_EN
    repeat (8) step();
    chk({31'b0, fetch_fault}, 32'd1, "fault_flag");
    chk(fault_pc, 32'h102, "fault_pc");
    chk({31'b0, imem_req_valid}, 32'd0, "fault_no_req");
    chk({31'b0, if_valid}, 32'd0, "fault_if_valid");
    redirect(32'h300);
    chk({31'b0, fetch_fault}, 32'd0, "fault_cleared");
    watch = 1'b1; watch_pc = 32'h300;
    repeat (6) step();
`else
    watch = 1'b1; watch_pc = 32'h102;
    repeat (6) step();
    chk({31'b0, watch}, 32'd0, "delivered_misaligned");
`endif

    // Stop fetching and let every outstanding instruction reach decode
    imem_req_ready = 1'b0;
    repeat (12) step();
    chk(32'(exp_q.size()), 32'd0, "final_scoreboard_empty");
    chk({31'b0, if_valid}, 32'd0, "final_if_valid");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
